// File: rtl/jtframe_linebuf_scan.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_linebuf_scan
// Purpose  : Double-buffered pixel line buffer between the tilemap renderer
//            and the video mixer. The renderer fills the write bank while
//            the scan side reads the other bank out in step with hdump.
//            Every rising edge of hs swaps the banks and kicks the renderer
//            with start. A renderer that is still busy is aborted with stop,
//            and the sticky late flag is set.
// Ports    : clk, rst              clock and synchronous active-high reset
//            pxl_cen, hs, LHBL     video timing inputs
//            hdump                 scan read position
//            start, stop, done     renderer handshake
//            buf_addr/data/wr      renderer write port
//            pxl                   scanned-out pixel
//            late                  sticky "line aborted before done" flag
// Options  : JTFRAME_LINEBUF_CLR_EN clears each entry as it is scanned out,
//            so entries the renderer skips on the next fill read back as 0.
// Revision : 1.0  initial release
// ============================================================================
module jtframe_linebuf_scan #(
  parameter int AW = 9,
  parameter int DW = 11
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          hs,
  input  logic          LHBL,
  input  logic [8:0]    hdump,
  output logic          start,
  output logic          stop,
  input  logic          done,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_wr,
  output logic [DW-1:0] pxl,
  output logic          late
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SWAP = 2'd1,
    ST_KICK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            hs_l_q;
  logic            bank_q;
  logic            busy_q;
  logic            late_q;
  logic [DW-1:0]   pxl_q;
  logic [AW-1:0]   w_rd_addr;
  logic            w_hs_edge;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [DW-1:0]   mem [0:(2<<AW)-1];

  assign w_rd_addr = AW'(hdump);
  assign w_hs_edge = hs & ~hs_l_q;

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_hs_edge) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        // busy_q has already been cleared if done coincided with the edge
        stop    = busy_q & ~rst;
        state_d = ST_KICK;
      end
      ST_KICK: begin
        start   = ~rst;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hs_l_q  <= 1'b0;
      bank_q  <= 1'b0;
      busy_q  <= 1'b0;
      late_q  <= 1'b0;
      pxl_q   <= '0;
    end else begin
      state_q <= state_d;
      hs_l_q  <= hs;
      if (state_q == ST_SWAP) bank_q <= ~bank_q;
      if (stop) late_q <= 1'b1;
      // A done arriving in the kick cycle belongs to the previous line,
      // so the new line's busy flag takes priority.
      if (done) busy_q <= 1'b0;
      if (state_q == ST_KICK) busy_q <= 1'b1;
      if (pxl_cen) pxl_q <= LHBL ? mem[{bank_q, w_rd_addr}] : '0;
    end
  end

  // RAM contents are deliberately not reset. The write bank uses the
  // current (pre-swap) bank_q, so a write in the swap cycle still lands in
  // the bank the renderer was filling.
  always_ff @(posedge clk) begin
    if (buf_wr) mem[{~bank_q, buf_addr}] <= buf_data;
`ifdef JTFRAME_LINEBUF_CLR_EN
    // Second port on the read bank: scanned entries become transparent.
    if (pxl_cen && LHBL) mem[{bank_q, w_rd_addr}] <= '0;
`endif
  end

  assign pxl  = pxl_q;
  assign late = late_q;

endmodule
`default_nettype wire
